// File: rtl/button_events.sv
// button_events: turns a debounced button level into edge pulses, a press
// counter, and single/double/long click events decoded by a small FSM.
// `release` is a reserved word in SystemVerilog, so the falling-edge pulse
// port is named `released`.
module button_events #(
  parameter int LONG_TICKS = 8,
  parameter int GAP_TICKS  = 6,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din,
  output logic             held,
  output logic             press,
  output logic             released,
  output logic             single_click,
  output logic             double_click,
  output logic             long_press,
  output logic [CNT_W-1:0] press_count
);

  // One counter serves as hold counter (DOWN1/DOWN2) and gap counter (WAIT_GAP).
  localparam int MAXC = (LONG_TICKS > GAP_TICKS + 1) ? LONG_TICKS : GAP_TICKS + 1;
  localparam int CW   = $clog2(MAXC + 1);

  typedef enum logic [2:0] {IDLE, DOWN1, WAIT_GAP, DOWN2, LONG_HELD} state_t;

  state_t        state, state_nx;
  logic [CW-1:0] cnt, cnt_nx, cnt_inc;
  logic          rise, fall;
  logic          sc_nx, dc_nx, lp_nx;

  assign rise = din & ~held;
  assign fall = ~din & held;

  // Next-state, counter and click-event decode.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    sc_nx    = 1'b0;
    dc_nx    = 1'b0;
    lp_nx    = 1'b0;
    cnt_inc  = (cnt == CW'(MAXC)) ? cnt : cnt + CW'(1);
    case (state)
      IDLE: begin
        if (rise) begin
          state_nx = DOWN1;
          cnt_nx   = CW'(1);
        end
      end
      DOWN1, DOWN2: begin
        // Release wins over long-press qualification on the same edge.
        if (!din) begin
          if (state == DOWN2) begin
            dc_nx    = 1'b1;
            state_nx = IDLE;
            cnt_nx   = '0;
          end else begin
            state_nx = WAIT_GAP;
            cnt_nx   = CW'(1);
          end
        end else begin
          cnt_nx = cnt_inc;
          if (cnt_inc >= CW'(LONG_TICKS)) begin
            // In DOWN2 the pending first click is simply dropped.
            lp_nx    = 1'b1;
            state_nx = LONG_HELD;
            cnt_nx   = '0;
          end
        end
      end
      WAIT_GAP: begin
        // A new press wins over gap expiry on the same edge.
        if (din) begin
          state_nx = DOWN2;
          cnt_nx   = CW'(1);
        end else begin
          cnt_nx = cnt_inc;
          if (cnt_inc >= CW'(GAP_TICKS + 1)) begin
            sc_nx    = 1'b1;
            state_nx = IDLE;
            cnt_nx   = '0;
          end
        end
      end
      LONG_HELD: begin
        if (!din) state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
        cnt_nx   = '0;
      end
    endcase
  end

  // State, counter and all registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      held         <= 1'b0;
      press        <= 1'b0;
      released     <= 1'b0;
      single_click <= 1'b0;
      double_click <= 1'b0;
      long_press   <= 1'b0;
      press_count  <= '0;
    end else begin
      state        <= state_nx;
      cnt          <= cnt_nx;
      held         <= din;
      press        <= rise;
      released     <= fall;
      single_click <= sc_nx;
      double_click <= dc_nx;
      long_press   <= lp_nx;
      if (rise) press_count <= press_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_button_events.sv
// Directed vector bench for button_events with default parameters.
module tb_button_events;

  logic       clk = 1'b0;
  logic       rst, din;
  logic       held, press, released, single_click, double_click, long_press;
  logic [7:0] press_count;

  int checks = 0;
  int errors = 0;

  // Expected event bits ordered {held, press, released, single, double, long}.
  typedef struct {
    logic       rst;
    logic       din;
    logic [5:0] ev;
    logic [7:0] cnt;
  } vec_t;

  vec_t vq[$];

  button_events dut (
    .clk(clk), .rst(rst), .din(din), .held(held), .press(press),
    .released(released), .single_click(single_click),
    .double_click(double_click), .long_press(long_press),
    .press_count(press_count)
  );

  always #5 clk = ~clk;

  task automatic add(input int n, input logic r, input logic d,
                     input logic [5:0] ev, input logic [7:0] c);
    vec_t v;
    v.rst = r; v.din = d; v.ev = ev; v.cnt = c;
    for (int i = 0; i < n; i++) vq.push_back(v);
  endtask

  task automatic step(input logic r, input logic d);
    @(negedge clk);
    rst = r; din = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [5:0] got;
    logic [7:0] expc;
    rst = 1'b1; din = 1'b0;

    // Single click: high 3, then single_click 6 edges after the release edge.
    add(2, 1, 0, 6'b000000, 0);
    add(1, 0, 1, 6'b110000, 1);
    add(2, 0, 1, 6'b100000, 1);
    add(1, 0, 0, 6'b001000, 1);
    add(5, 0, 0, 6'b000000, 1);
    add(1, 0, 0, 6'b000100, 1);
    add(2, 0, 0, 6'b000000, 1);
    // Double click: high 3, low 4, high 3, low.
    add(1, 1, 0, 6'b000000, 0);
    add(1, 0, 1, 6'b110000, 1);
    add(2, 0, 1, 6'b100000, 1);
    add(1, 0, 0, 6'b001000, 1);
    add(3, 0, 0, 6'b000000, 1);
    add(1, 0, 1, 6'b110000, 2);
    add(2, 0, 1, 6'b100000, 2);
    add(1, 0, 0, 6'b001010, 2);
    add(8, 0, 0, 6'b000000, 2);
    // Gap boundary: second press at release+6 still counts as a double.
    add(1, 1, 0, 6'b000000, 0);
    add(1, 0, 1, 6'b110000, 1);
    add(1, 0, 0, 6'b001000, 1);
    add(5, 0, 0, 6'b000000, 1);
    add(1, 0, 1, 6'b110000, 2);
    add(1, 0, 0, 6'b001010, 2);
    add(8, 0, 0, 6'b000000, 2);
    // Gap boundary: press at release+7 -> single at +6, then a fresh click.
    add(1, 1, 0, 6'b000000, 0);
    add(1, 0, 1, 6'b110000, 1);
    add(1, 0, 0, 6'b001000, 1);
    add(5, 0, 0, 6'b000000, 1);
    add(1, 0, 0, 6'b000100, 1);
    add(1, 0, 1, 6'b110000, 2);
    add(1, 0, 0, 6'b001000, 2);
    add(5, 0, 0, 6'b000000, 2);
    add(1, 0, 0, 6'b000100, 2);
    // Long press: high 12 edges, long_press after 8th, silent release.
    add(1, 1, 0, 6'b000000, 0);
    add(1, 0, 1, 6'b110000, 1);
    add(6, 0, 1, 6'b100000, 1);
    add(1, 0, 1, 6'b100001, 1);
    add(3, 0, 1, 6'b100000, 1);
    add(1, 0, 0, 6'b001000, 1);
    add(8, 0, 0, 6'b000000, 1);
    // Falling at edge 8 beats long-press qualification -> single click.
    add(1, 1, 0, 6'b000000, 0);
    add(1, 0, 1, 6'b110000, 1);
    add(6, 0, 1, 6'b100000, 1);
    add(1, 0, 0, 6'b001000, 1);
    add(5, 0, 0, 6'b000000, 1);
    add(1, 0, 0, 6'b000100, 1);
    add(2, 0, 0, 6'b000000, 1);
    // Long press out of DOWN2 drops the first click.
    add(1, 1, 0, 6'b000000, 0);
    add(1, 0, 1, 6'b110000, 1);
    add(1, 0, 0, 6'b001000, 1);
    add(1, 0, 1, 6'b110000, 2);
    add(6, 0, 1, 6'b100000, 2);
    add(1, 0, 1, 6'b100001, 2);
    add(1, 0, 0, 6'b001000, 2);
    add(8, 0, 0, 6'b000000, 2);
    // Reset in WAIT_GAP with din low: pending single is discarded.
    add(1, 1, 0, 6'b000000, 0);
    add(1, 0, 1, 6'b110000, 1);
    add(1, 0, 0, 6'b001000, 1);
    add(2, 0, 0, 6'b000000, 1);
    add(1, 1, 0, 6'b000000, 0);
    add(8, 0, 0, 6'b000000, 0);
    // Reset in WAIT_GAP with din high: press on first post-reset edge.
    add(1, 0, 1, 6'b110000, 1);
    add(1, 0, 0, 6'b001000, 1);
    add(2, 0, 0, 6'b000000, 1);
    add(1, 1, 1, 6'b000000, 0);
    add(1, 0, 1, 6'b110000, 1);
    add(1, 0, 0, 6'b001000, 1);
    add(5, 0, 0, 6'b000000, 1);
    add(1, 0, 0, 6'b000100, 1);

    foreach (vq[i]) begin
      step(vq[i].rst, vq[i].din);
      got = {held, press, released, single_click, double_click, long_press};
      checks++;
      if (got !== vq[i].ev) begin
        errors++;
        $display("FAIL vec %0d events got %b want %b", i, got, vq[i].ev);
      end
      checks++;
      if (press_count !== vq[i].cnt) begin
        errors++;
        $display("FAIL vec %0d press_count got %0d want %0d", i, press_count, vq[i].cnt);
      end
    end

    // press_count wrap: 256 presses bring it back to 0.
    step(1, 0);
    for (int i = 0; i < 256; i++) begin
      step(0, 1);
      expc = 8'((i + 1) % 256);
      checks++;
      if (press_count !== expc) begin
        errors++;
        $display("FAIL wrap press %0d press_count got %0d want %0d", i, press_count, expc);
      end
      step(0, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Click events are mutually exclusive in every cycle.
  always @(negedge clk) begin
    if (rst === 1'b0 && ($countones({single_click, double_click, long_press}) > 1)) begin
      errors++;
      $display("FAIL exclusive events got %b want at most one",
               {single_click, double_click, long_press});
    end
  end

endmodule

// File: doc/button_events.md
BUTTON_EVENTS -- requirements
Module: button_events

Interface
REQ-001 The module SHALL have parameter LONG_TICKS, default 8, meaning cycles held high for a long press (legal range >= 2).
REQ-002 The module SHALL have parameter GAP_TICKS, default 6, meaning maximum low cycles between clicks of a double click (legal range >= 1).
REQ-003 The module SHALL have parameter CNT_W, default 8, meaning press_count width.
REQ-004 The module SHALL have port clk  input  1  the single clock; all logic is on its rising edge.
REQ-005 The module SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-006 The module SHALL have port din  input  1  debounced button level from the debounce stage, already synchronous to clk.
REQ-007 The module SHALL have port held  output  1  registered copy of din.
REQ-008 The module SHALL have port press  output  1  one-cycle pulse on a rising edge of held.
REQ-009 The module SHALL have port release  output  1  one-cycle pulse on a falling edge of held.
REQ-010 The module SHALL have port single_click  output  1  one-cycle pulse for a confirmed single short click.
REQ-011 The module SHALL have port double_click  output  1  one-cycle pulse for two short clicks within the gap.
REQ-012 The module SHALL have port long_press  output  1  one-cycle pulse when a press reaches LONG_TICKS.
REQ-013 The module SHALL have port press_count  output  CNT_W  running count of press pulses.

Function
REQ-014 All outputs SHALL be registered, so an event sampled on din at edge e appears on outputs after edge e.
REQ-015 At edge e with din=1 and held=0, the module SHALL set held=1 and assert press for exactly one cycle; release SHALL mirror this for din=0 and held=1.
REQ-016 press_count SHALL increment by 1 on every press pulse and wrap modulo 2^CNT_W (all-ones -> 0).
REQ-017 The FSM SHALL have exactly the states IDLE, DOWN1, WAIT_GAP, DOWN2 and LONG_HELD.
REQ-018 In IDLE, a press SHALL move the FSM to DOWN1 with hold counter = 1.
REQ-019 In DOWN1 or DOWN2, the hold counter SHALL increment once per edge with din=1.
REQ-020 In DOWN1 or DOWN2, when din=1 is sampled and the count reaches LONG_TICKS, the module SHALL pulse long_press and move to LONG_HELD; in DOWN2 the pending first click is then discarded with no single_click.
REQ-021 In DOWN1 or DOWN2, release (din=0) SHALL take priority over long-press qualification on the same edge.
REQ-022 In DOWN1, a release SHALL move the FSM to WAIT_GAP with gap counter = 1.
REQ-023 In WAIT_GAP, the gap counter SHALL increment per edge with din=0.
REQ-024 In WAIT_GAP, a press SHALL move the FSM to DOWN2 with hold counter = 1.
REQ-025 In WAIT_GAP, when the counter reaches GAP_TICKS+1 with no press, the module SHALL pulse single_click and move to IDLE.
REQ-026 In WAIT_GAP, a press SHALL take priority over gap expiry on the same edge.
REQ-027 In DOWN2, a release SHALL pulse double_click in the same cycle as release and move to IDLE.
REQ-028 In LONG_HELD, a release SHALL pulse release only, with no click output, and move to IDLE.
REQ-029 At most one of single_click, double_click and long_press SHALL be high in any cycle.
REQ-030 Counters SHALL be sized to hold max(LONG_TICKS, GAP_TICKS+1) and saturate, never wrap.

Reset
REQ-031 While rst=1 at an edge, the module SHALL set state=IDLE, all counters=0, held=0, press_count=0 and all pulse outputs=0.
REQ-032 A reset asserted mid-operation SHALL discard any pending click or long press without emitting a pulse.
REQ-033 If din=1 at the first edge with rst=0, the module SHALL pulse press, since held was cleared.

Verification
REQ-034 Single click (defaults): din high for 3 edges then low -> press, release, then single_click exactly 6 edges after the release edge; press_count=1.
REQ-035 Double click: din high 3, low 4, high 3, low -> two press pulses, double_click coincident with the 2nd release, no single_click; press_count=2.
REQ-036 Gap boundary: second press sampled at release edge +6 -> double_click path; second press at release edge +7 -> single_click at +6, then a new DOWN1.
REQ-037 Long press: din high 12 edges -> long_press after the 8th high edge, one cycle only; release at 12 -> release pulse, no click pulses; din falling at edge 8 instead -> single_click path.
REQ-038 Wrap and reset: 256 presses -> press_count returns to 0; rst pulsed during WAIT_GAP -> no single_click, outputs 0, press on the first post-reset edge if din=1.
